// File: rtl/vec_mem_pkg.sv
// Shared parameters and types for the 4-lane vector data memory.
package vec_mem_pkg;
  localparam int unsigned DEPTH_DEF = 1024;
  localparam int unsigned AW_DEF    = 10;
  localparam int unsigned LANES     = 4;
  localparam int unsigned DW        = 32;
  localparam int unsigned WCW       = 16;

  typedef enum logic [0:0] {
    HOST_IDLE = 1'b0,
    HOST_RESP = 1'b1
  } host_state_e;
endpackage

// File: rtl/vec_mem_bank.sv
// Word storage with LANES write ports and LANES registered write-first read ports,
// plus an unregistered host read port.
module vec_mem_bank
  import vec_mem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANES-1:0]             we_i,
  input  logic [LANES-1:0][AW-1:0]     waddr_i,
  input  logic [LANES-1:0][DW-1:0]     wdata_i,
  input  logic [LANES-1:0][AW-1:0]     raddr_i,
  input  logic [AW-1:0]                host_raddr_i,
  output logic [LANES-1:0][DW-1:0]     rdata_o,
  output logic [DW-1:0]                host_rdata_c
);

  logic [DW-1:0]             mem_q [DEPTH];
  logic [LANES-1:0][DW-1:0]  rdata_d;
  logic [LANES-1:0][DW-1:0]  rdata_q;

  // Lane addresses are distinct, so no two enabled lanes collide on one word.
  always_ff @(posedge clk) begin
    for (int w = 0; w < int'(LANES); w++) begin
      if (we_i[w]) begin
        mem_q[waddr_i[w]] <= wdata_i[w];
      end
    end
  end

  // Write-first: a same-cycle write to the read word bypasses the array.
  always_comb begin
    rdata_d = '0;
    for (int r = 0; r < int'(LANES); r++) begin
      rdata_d[r] = mem_q[raddr_i[r]];
      for (int w = 0; w < int'(LANES); w++) begin
        if (we_i[w] && (waddr_i[w] == raddr_i[r])) begin
          rdata_d[r] = wdata_i[w];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o      = rdata_q;
  assign host_rdata_c = mem_q[host_raddr_i];

endmodule

// File: rtl/vector_data_mem.sv
// Vector data memory: CPU 4-lane read/write port with priority over a
// single-word host port, host read-response FSM and a saturating write counter.
module vector_data_mem
  import vec_mem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    rd_addr,
  input  logic           mem_wr_enable,
  input  logic           wr_sc,
  input  logic [31:0]    wr_addr,
  input  logic [31:0]    wd1,
  input  logic [31:0]    wd2,
  input  logic [31:0]    wd3,
  input  logic [31:0]    wd4,
  output logic [31:0]    rd1,
  output logic [31:0]    rd2,
  output logic [31:0]    rd3,
  output logic [31:0]    rd4,
  input  logic           host_valid,
  input  logic           host_we,
  input  logic [AW-1:0]  host_addr,
  input  logic [31:0]    host_wdata,
  output logic           host_ready,
  output logic           host_rvalid,
  output logic [31:0]    host_rdata,
  output logic [15:0]    wr_count
);

  logic                      cpu_we;
  logic                      host_wr_acc;
  logic                      host_rd_acc;
  logic [LANES-1:0]          lane_we;
  logic [LANES-1:0][AW-1:0]  lane_waddr;
  logic [LANES-1:0][DW-1:0]  lane_wdata;
  logic [LANES-1:0][AW-1:0]  lane_raddr;
  logic [LANES-1:0][DW-1:0]  lane_rdata;
  logic [DW-1:0]             host_word_c;
  host_state_e               state_q, state_d;
  logic [DW-1:0]             host_rdata_q, host_rdata_d;
  logic [WCW-1:0]            wr_count_q, wr_count_d;
  logic                      unused_addr_hi;

  assign unused_addr_hi = ^{rd_addr[31:AW], wr_addr[31:AW]};

  // CPU writes win; nothing is accepted while in reset.
  assign cpu_we      = mem_wr_enable & ~rst;
  assign host_ready  = host_valid & ~mem_wr_enable & ~rst;
  assign host_wr_acc = host_ready & host_we;
  assign host_rd_acc = host_ready & ~host_we;

  // Lane k targets base + k; AW-bit addition wraps modulo DEPTH.
  always_comb begin
    lane_wdata = {wd4, wd3, wd2, wd1};
    for (int k = 0; k < int'(LANES); k++) begin
      lane_waddr[k] = wr_addr[AW-1:0] + AW'(k);
      lane_raddr[k] = rd_addr[AW-1:0] + AW'(k);
      lane_we[k]    = cpu_we & ((k == 0) | ~wr_sc);
    end
    if (host_wr_acc) begin
      lane_we[0]    = 1'b1;
      lane_waddr[0] = host_addr;
      lane_wdata[0] = host_wdata;
    end
  end

  vec_mem_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk          (clk),
    .rst          (rst),
    .we_i         (lane_we),
    .waddr_i      (lane_waddr),
    .wdata_i      (lane_wdata),
    .raddr_i      (lane_raddr),
    .host_raddr_i (host_addr),
    .rdata_o      (lane_rdata),
    .host_rdata_c (host_word_c)
  );

  assign rd1 = lane_rdata[0];
  assign rd2 = lane_rdata[1];
  assign rd3 = lane_rdata[2];
  assign rd4 = lane_rdata[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HOST_IDLE;
      host_rdata_q <= '0;
      wr_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      host_rdata_q <= host_rdata_d;
      wr_count_q   <= wr_count_d;
    end
  end

  // Every accepted read (from IDLE or RESP) yields exactly one response cycle.
  always_comb begin
    state_d      = HOST_IDLE;
    host_rdata_d = host_rdata_q;
    wr_count_d   = wr_count_q;
    if (host_rd_acc) begin
      state_d      = HOST_RESP;
      host_rdata_d = host_word_c;
    end
    if (cpu_we && (wr_count_q != '1)) begin
      wr_count_d = wr_count_q + WCW'(1);
    end
  end

  assign host_rvalid = (state_q == HOST_RESP);
  assign host_rdata  = host_rdata_q;
  assign wr_count    = wr_count_q;

endmodule
